mem_initiator: RTL

Initiator side of the level-sensitive ren/wen/addr/din/dout data-memory interface. Accepts single load/store requests from the CPU datapath over a valid/ready handshake, sequences the memory strobes so address and write data are stable around every strobe, and ensures ren and wen are never active together. Returns the read data or a store acknowledge over a valid/ready response channel. Sits between the datapath's load/store stage and the data Memory instance.

---
 rtl/mem_initiator_pkg.sv | 27 ++
 rtl/mem_initiator_if.sv | 39 +++
 rtl/mem_initiator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_initiator_pkg.sv
// ============================================================================
// mem_initiator_pkg : shared constants, state encodings and helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_initiator_pkg;

  typedef logic [2:0] mi_state_t;

  localparam mi_state_t MI_IDLE   = 3'd0;
  localparam mi_state_t MI_SETUP  = 3'd1;
  localparam mi_state_t MI_STROBE = 3'd2;
  localparam mi_state_t MI_HOLD   = 3'd3;
  localparam mi_state_t MI_RESP   = 3'd4;

  localparam int MEM_ADDR_LSB_WIDTH    = 12;
  localparam int STROBE_CYCLES_DEFAULT = 1;
  localparam int STROBE_CNT_WIDTH      = 4;

  function automatic logic addr_out_of_range(input logic [31:0] addr);
    return |addr[31:MEM_ADDR_LSB_WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_initiator_if.sv
// ============================================================================
// mem_initiator_if : request/response channels plus data-memory strobe bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_initiator_if;
  import mem_initiator_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_ren, mem_wen, mem_addr, mem_din
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_ren, mem_wen, mem_addr, mem_din
  );

endinterface

`default_nettype wire

// File: rtl/mem_initiator.sv
// ============================================================================
// mem_initiator : sequences single load/store requests onto a level-sensitive
//                 ren/wen data-memory interface with registered strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_initiator_if.master  bus
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe_cycles
    $error("mem_initiator: STROBE_CYCLES=%0d outside legal range 1..15", STROBE_CYCLES);
  end

  localparam logic [STROBE_CNT_WIDTH-1:0] C_CNT_LOAD = STROBE_CNT_WIDTH'(STROBE_CYCLES - 1);

  mi_state_t                   r_state;
  mi_state_t                   w_state_next;
  logic [STROBE_CNT_WIDTH-1:0] r_cnt;
  logic                        r_write;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_mem_ren;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;

  logic w_req_ready;
  logic w_resp_valid;
  logic w_mem_ren;
  logic w_mem_wen;
  logic w_accept;
  logic w_addr_err;
  logic w_strobe_last;

  assign w_accept      = (r_state == MI_IDLE) && bus.req_valid;
  assign w_addr_err    = addr_out_of_range(bus.req_addr);
  assign w_strobe_last = (r_state == MI_STROBE) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MI_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MI_IDLE:   if (bus.req_valid) w_state_next = w_addr_err ? MI_RESP : MI_SETUP;
      MI_SETUP:  w_state_next = MI_STROBE;
      MI_STROBE: if (r_cnt == '0) w_state_next = MI_HOLD;
      MI_HOLD:   w_state_next = MI_RESP;
      MI_RESP:   if (bus.resp_ready) w_state_next = MI_IDLE;
      default:   w_state_next = MI_IDLE;
    endcase
  end

  // Outputs decode the next state so they can be registered glitch-free;
  // r_write is already settled whenever STROBE is entered (always from SETUP).
  always_comb begin
    w_req_ready  = (w_state_next == MI_IDLE);
    w_resp_valid = (w_state_next == MI_RESP);
    w_mem_ren    = (w_state_next == MI_STROBE) && !r_write;
    w_mem_wen    = (w_state_next == MI_STROBE) &&  r_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_cnt        <= '0;
      r_write      <= 1'b0;
    end else begin
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_mem_ren    <= w_mem_ren;
      r_mem_wen    <= w_mem_wen;

      if (w_accept) begin
        r_write      <= bus.req_write;
        r_resp_err   <= w_addr_err;
        r_resp_rdata <= '0;
        // Address/data move only when heading into SETUP, never on an error.
        if (!w_addr_err) begin
          r_mem_addr <= bus.req_addr;
          if (bus.req_write) begin
            r_mem_din <= bus.req_wdata;
          end
        end
      end

      if (r_state == MI_SETUP) begin
        r_cnt <= C_CNT_LOAD;
      end else if ((r_state == MI_STROBE) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_strobe_last && !r_write) begin
        r_resp_rdata <= bus.mem_dout;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_ren    = r_mem_ren;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;

endmodule

`default_nettype wire
